// File: rtl/stream_packer.sv
// stream_packer: packs 32-bit words into SIZE-bit blocks with valid/ready on both sides.
// Optional row-ordered packing for SIZE==128 is enabled by defining STREAM_PACKER_ROW_MODE_EN.
module stream_packer #(
   parameter int SIZE = 128
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            row_mode,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_word,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_block,
   output logic [2:0]      word_cnt
);
   localparam int WORDS = SIZE / 32;
   localparam logic [2:0] LAST = 3'(WORDS - 1);
`ifdef STREAM_PACKER_ROW_MODE_EN
   localparam bit ROW_EN = SIZE == 128;
`else
   localparam bit ROW_EN = 1'b0;
`endif
   typedef enum logic {FILL, FULL} state_t;
   state_t          state_q;
   logic [2:0]      cnt_q;
   logic            row_q;
   logic            valid_q;
   logic [SIZE-1:0] block_q;
   logic            accept;
   logic            row_sel;
   logic [2:0]      idx;
   assign in_ready  = (state_q == FILL) || out_ready;
   assign accept    = in_valid && in_ready && !(state_q == FILL && flush);
   // a word taken while FULL is word 0 of the next block
   assign idx       = (state_q == FILL) ? cnt_q : 3'd0;
   assign row_sel   = ROW_EN && ((idx == 3'd0) ? row_mode : row_q);
   assign out_valid = valid_q;
   assign out_block = block_q;
   assign word_cnt  = cnt_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FILL;
         cnt_q   <= 3'd0;
         row_q   <= 1'b0;
         valid_q <= 1'b0;
         block_q <= '0;
      end else begin
         if (state_q == FULL && out_ready) begin
            state_q <= FILL;
            valid_q <= 1'b0;
         end
         if (state_q == FILL && flush)
            cnt_q <= 3'd0;
         if (accept) begin
            if (idx == 3'd0)
               row_q <= row_mode;
            if (row_sel) begin
               for (int c = 0; c < 4; c++)
                  block_q[(4 * c + int'(idx[1:0])) * 8 +: 8] <= in_word[c * 8 +: 8];
            end else begin
               block_q[idx * 32 +: 32] <= in_word;
            end
            if (idx == LAST) begin
               state_q <= FULL;
               valid_q <= 1'b1;
               cnt_q   <= 3'd0;
            end else begin
               cnt_q <= idx + 3'd1;
            end
         end
      end
   end
endmodule
